// File: rtl/mod47_mul_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mod47_mul_arb
//  Description : Four-way round-robin arbiter feeding a constant modulo-47
//                multiplier with a ready/valid result port.
//                Define MOD47_ARB_OUTREG_EN to add an operand register stage
//                in front of the result register (latency 2 instead of 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module mod47_mul_arb #(
    parameter int unsigned MUL_CONST = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [23:0] req_data,
    output logic [3:0]  req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [5:0]  rsp_data,
    output logic [1:0]  rsp_id,
    output logic        busy
);

    localparam logic [11:0] c_mod = 12'd47;
    localparam logic [11:0] c_mul = 12'(MUL_CONST);

    logic [1:0]  r_ptr;
    logic [1:0]  w_gnt;
    logic        w_any;
    logic        w_in_ready;
    logic        w_accept;
    logic [5:0]  w_op;
    logic        w_out_free;
    logic        w_load_out;
    logic [5:0]  w_mul_in;
    logic [1:0]  w_mul_id;
    logic [11:0] w_prod;
    logic [5:0]  w_res;
    logic        r_rsp_valid;
    logic [5:0]  r_rsp_data;
    logic [1:0]  r_rsp_id;

    // Scan from the highest offset down so the requester closest to r_ptr wins.
    always_comb begin
        w_any = 1'b0;
        w_gnt = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req_valid[r_ptr + 2'(k)]) begin
                w_any = 1'b1;
                w_gnt = r_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        w_op = req_data[5:0];
        case (w_gnt)
            2'd0:    w_op = req_data[5:0];
            2'd1:    w_op = req_data[11:6];
            2'd2:    w_op = req_data[17:12];
            default: w_op = req_data[23:18];
        endcase
    end

    assign w_out_free = !r_rsp_valid || rsp_ready;
    assign w_accept   = !rst && w_any && w_in_ready;
    assign req_ready  = w_accept ? (4'b0001 << w_gnt) : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 2'd0;
        end else if (w_accept) begin
            r_ptr <= w_gnt + 2'd1;
        end
    end

`ifdef MOD47_ARB_OUTREG_EN
    logic       r_s1_valid;
    logic [5:0] r_s1_data;
    logic [1:0] r_s1_id;

    // Stage 1 moves forward whenever the result register is empty or retiring.
    assign w_load_out = r_s1_valid && w_out_free;
    assign w_in_ready = !r_s1_valid || w_out_free;
    assign w_mul_in   = r_s1_data;
    assign w_mul_id   = r_s1_id;
    assign busy       = r_s1_valid || r_rsp_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= 6'd0;
            r_s1_id    <= 2'd0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= w_op;
            r_s1_id    <= w_gnt;
        end else if (w_load_out) begin
            r_s1_valid <= 1'b0;
        end
    end
`else
    assign w_load_out = w_accept;
    assign w_in_ready = w_out_free;
    assign w_mul_in   = w_op;
    assign w_mul_id   = w_gnt;
    assign busy       = r_rsp_valid;
`endif

    // Operands 47..63 need no pre-reduction: the full product is reduced once.
    assign w_prod = {6'd0, w_mul_in} * c_mul;
    assign w_res  = 6'(w_prod % c_mod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 6'd0;
            r_rsp_id    <= 2'd0;
        end else if (w_load_out) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_res;
            r_rsp_id    <= w_mul_id;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;

endmodule
`default_nettype wire

// File: tb/tb_mod47_mul_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod47_mul_arb
//  Description : Self-checking bench for mod47_mul_arb; honours
//                MOD47_ARB_OUTREG_EN for the expected latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod47_mul_arb;

`ifdef MOD47_ARB_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = 4'd0;
    logic [23:0] req_data = 24'd0;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [5:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_popped = 0;

    // Scoreboard entries are {id, result}.
    logic [7:0] sb[$];
    logic [1:0] m_ptr = 2'd0;
    logic [1:0] m_g;
    logic       m_found;
    logic [7:0] m_e;
    int         m_x;
    logic       hold_prev = 1'b0;
    logic [5:0] prev_data;
    logic [1:0] prev_id;

    mod47_mul_arb #(.MUL_CONST(26)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] ref_mod(input int x);
        return 6'((x * 26) % 47);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbiter and in-order scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_ptr     = 2'd0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== prev_data || rsp_id !== prev_id) begin
                    n_fail++;
                    $display("FAIL hold_stable: got v=%b d=%0d id=%0d, need v=1 d=%0d id=%0d",
                             rsp_valid, rsp_data, rsp_id, prev_data, prev_id);
                end
            end
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got d=%0d id=%0d, need no result", rsp_data, rsp_id);
                end else begin
                    m_e = sb.pop_front();
                    n_popped++;
                    if ({rsp_id, rsp_data} !== m_e) begin
                        n_fail++;
                        $display("FAIL sb_result: got id=%0d d=%0d, need id=%0d d=%0d",
                                 rsp_id, rsp_data, m_e[7:6], m_e[5:0]);
                    end
                end
            end
            hold_prev = (rsp_valid === 1'b1) && (rsp_ready === 1'b0);
            prev_data = rsp_data;
            prev_id   = rsp_id;

            m_found = 1'b0;
            m_g     = m_ptr;
            for (int k = 0; k < 4; k++) begin
                if (!m_found && req_valid[(int'(m_ptr) + k) % 4]) begin
                    m_found = 1'b1;
                    m_g     = 2'((int'(m_ptr) + k) % 4);
                end
            end
            if (req_ready !== 4'b0000) begin
                n_checks++;
                if (!m_found || req_ready !== (4'b0001 << m_g)) begin
                    n_fail++;
                    $display("FAIL grant: got req_ready=%b, need %b (valid=%b)",
                             req_ready, m_found ? (4'b0001 << m_g) : 4'b0000, req_valid);
                end
                m_x = int'((req_data >> (6 * int'(m_g))) & 24'h3f);
                sb.push_back({m_g, ref_mod(m_x)});
                m_ptr = m_g + 2'd1;
            end
        end
    end

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = 4'd0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'hf;
        req_data  = 24'h123456;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b, need 0", rsp_valid); end
        n_checks++;
        if (rsp_data !== 6'd0) begin n_fail++; $display("FAIL reset_rsp_data: got %0d, need 0", rsp_data); end
        n_checks++;
        if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d, need 0", rsp_id); end
        n_checks++;
        if (req_ready !== 4'd0) begin n_fail++; $display("FAIL reset_req_ready: got %b, need 0000", req_ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, need 0", busy); end
        tick();
        rst       = 1'b0;
        req_valid = 4'd0;
        req_data  = 24'd0;
    endtask

    task automatic test_single();
        req_valid = 4'b0001;
        req_data  = 24'd1;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL first_accept: got %b, need 0001", req_ready); end
        tick();
        req_valid = 4'd0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            n_checks++;
            if (k < LAT) begin
                if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got v=%b at edge %0d, need 0", rsp_valid, k); end
            end else if (rsp_valid !== 1'b1 || rsp_data !== 6'd26 || rsp_id !== 2'd0) begin
                n_fail++;
                $display("FAIL single_result: got v=%b d=%0d id=%0d, need v=1 d=26 id=0", rsp_valid, rsp_data, rsp_id);
            end
            tick();
        end
        repeat (3) tick();
    endtask

    task automatic test_reduction();
        int xs[4]  = '{2, 46, 47, 63};
        int exp[4] = '{5, 21, 0, 40};
        logic got;
        logic seen;
        logic [5:0] d;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_data  = 24'(xs[i]) << 6;
            req_valid = 4'b0010;
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk);
                got = (req_ready !== 4'd0);
                tick();
            end
            req_valid = 4'd0;
            seen = 1'b0;
            d    = 6'd0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                if (rsp_valid === 1'b1) begin seen = 1'b1; d = rsp_data; end
                tick();
            end
            n_checks++;
            if (!seen) begin
                n_fail++;
                $display("FAIL reduce_timeout: got no result for x=%0d, need %0d", xs[i], exp[i]);
            end else if (d !== 6'(exp[i])) begin
                n_fail++;
                $display("FAIL reduce_x%0d: got %0d, need %0d", xs[i], d, exp[i]);
            end
        end
    endtask

    task automatic test_fairness();
        int ids[$];
        apply_reset();
        req_data  = {6'd13, 6'd12, 6'd11, 6'd10};
        req_valid = 4'hf;
        rsp_ready = 1'b1;
        for (int c = 0; c < 8 + LAT + 3; c++) begin
            @(negedge clk);
            if (c < 8) begin
                n_checks++;
                if (req_ready === 4'd0) begin n_fail++; $display("FAIL throughput: got req_ready=0000 at cycle %0d, need a grant", c); end
            end
            if (rsp_valid === 1'b1) ids.push_back(int'(rsp_id));
            tick();
            if (c == 7) req_valid = 4'd0;
        end
        n_checks++;
        if (ids.size() != 8) begin n_fail++; $display("FAIL fair_count: got %0d results, need 8", ids.size()); end
        for (int i = 0; i < ids.size(); i++) begin
            n_checks++;
            if (ids[i] != i % 4) begin n_fail++; $display("FAIL fair_order[%0d]: got id=%0d, need %0d", i, ids[i], i % 4); end
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] first_d;
        first_d   = 6'd0;
        rsp_ready = 1'b0;
        req_data  = {6'd0, 6'd50, 6'd0, 6'd33};
        req_valid = 4'b0101;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == LAT) first_d = rsp_data;
            if (c == 4) begin
                n_checks++;
                if (req_ready !== 4'd0) begin n_fail++; $display("FAIL bp_full: got req_ready=%b, need 0000", req_ready); end
                n_checks++;
                if (busy !== 1'b1 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_busy: got busy=%b v=%b, need 1 1", busy, rsp_valid); end
                n_checks++;
                if (rsp_data !== first_d) begin n_fail++; $display("FAIL bp_stable: got %0d, need %0d", rsp_data, first_d); end
            end
            tick();
        end
        req_valid = 4'd0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
        repeat (2) tick();
        n_checks++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d pending busy=%b, need 0 pending busy=0", sb.size(), busy);
        end
    endtask

    task automatic test_reset_midflight();
        req_data  = 24'($urandom);
        req_valid = 4'hf;
        rsp_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b, need 1", busy); end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b busy=%b rr=%b, need 0 0 0000", rsp_valid, busy, req_ready);
        end
        req_valid = 4'd0;
        @(negedge clk);
        tick();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale: got v=%b d=%0d, need v=0", rsp_valid, rsp_data); end
            tick();
        end
    endtask

    task automatic test_sweep();
        int   base;
        int   r;
        logic got;
        base = n_popped;
        for (int x = 0; x < 64; x++) begin
            r = int'($urandom_range(0, 3));
            req_data = 24'($urandom);
            req_data[6*r +: 6] = 6'(x);
            req_valid = 4'b0001 << r;
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge clk);
                got = (req_ready !== 4'd0);
                tick();
                rsp_ready = 1'($urandom);
            end
            req_valid = 4'd0;
            n_checks++;
            if (!got) begin n_fail++; $display("FAIL sweep_accept: got no grant for x=%0d req=%0d, need a grant", x, r); end
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
        repeat (2) tick();
        n_checks++;
        if (n_popped - base != 64) begin n_fail++; $display("FAIL sweep_count: got %0d results, need 64", n_popped - base); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reduction();
        test_fairness();
        test_backpressure();
        test_reset_midflight();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000, need completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
